// File: rtl/mem_bus_decoder.sv
// Memory-bus decoder/responder: maps the core data port onto N slave regions
// by ADDR[31:16] tag, with registered chip selects, a READY timeout and an
// error log (last failing address plus a saturating error count).
module mem_bus_decoder #(
    parameter int unsigned                 NUM_REGIONS = 2,
    parameter logic [16*NUM_REGIONS-1:0]   REGION_BASE = {16'h1001, 16'h0040},
    parameter int unsigned                 TIMEOUT     = 16,
    parameter logic [31:0]                 ERR_RDATA   = 32'hDEADBEEF
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          M_REQ,
    input  logic [31:0]                   M_ADDR,
    input  logic [1:0]                    M_WR_EN,
    input  logic [31:0]                   M_WDATA,
    output logic [31:0]                   M_RDATA,
    output logic                          M_ACK,
    output logic                          M_ERR,
    output logic [NUM_REGIONS-1:0]        S_CS,
    output logic [15:0]                   S_ADDR,
    output logic [1:0]                    S_WR_EN,
    output logic [31:0]                   S_WDATA,
    input  logic [32*NUM_REGIONS-1:0]     S_RDATA,
    input  logic [NUM_REGIONS-1:0]        S_READY,
    output logic [31:0]                   ERR_ADDR,
    output logic [7:0]                    ERR_CNT
);

    localparam int IW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP, ST_ERR} state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [NUM_REGIONS-1:0]   cs_q, cs_d;
    logic [31:0]              addr_q, addr_d;
    logic [1:0]               wr_q, wr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [31:0]              err_addr_q, err_addr_d;
    logic [7:0]               err_cnt_q, err_cnt_d;

    logic                     hit;
    logic [IW-1:0]            hit_idx;
    logic [NUM_REGIONS-1:0]   hit_cs;
    logic                     rdy_sel;
    logic [31:0]              rdata_sel;
    logic                     tmo;
    logic [7:0]               err_cnt_inc;

    // Tag decode; scanning downwards lets the lowest matching region win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_cs  = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (M_ADDR[31:16] == REGION_BASE[16*i +: 16]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
        for (int i = 0; i < NUM_REGIONS; i++) begin
            hit_cs[i] = (hit_idx == IW'(i));
        end
    end

    // Only the latched region's READY/RDATA are looked at.
    always_comb begin
        rdy_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (idx_q == IW'(i)) begin
                rdy_sel   = S_READY[i];
                rdata_sel = S_RDATA[32*i +: 32];
            end
        end
    end

    assign tmo         = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);
    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // Next-state and registered-output logic; outputs take effect in the
    // state being entered, so ACK/ERR/CS never depend on combinational paths.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cs_d       = cs_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (M_REQ) begin
                    if (hit) begin
                        idx_d   = hit_idx;
                        cs_d    = hit_cs;
                        addr_d  = M_ADDR;
                        wr_d    = M_WR_EN;
                        wdata_d = M_WDATA;
                        cnt_d   = '0;
                        state_d = ST_ACCESS;
                    end else begin
                        err_addr_d = M_ADDR;
                        err_cnt_d  = err_cnt_inc;
                        rdata_d    = ERR_RDATA;
                        ack_d      = 1'b1;
                        err_d      = 1'b1;
                        state_d    = ST_ERR;
                    end
                end
            end
            ST_ACCESS: begin
                if (rdy_sel) begin
                    if (wr_q == 2'b00) rdata_d = rdata_sel;
                    ack_d   = 1'b1;
                    cs_d    = '0;
                    wr_d    = 2'b00;
                    state_d = ST_RESP;
                end else if (tmo) begin
                    err_addr_d = addr_q;
                    err_cnt_d  = err_cnt_inc;
                    rdata_d    = ERR_RDATA;
                    ack_d      = 1'b1;
                    err_d      = 1'b1;
                    cs_d       = '0;
                    wr_d       = 2'b00;
                    state_d    = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; async reset clears everything, aborting any access.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cs_q       <= '0;
            addr_q     <= '0;
            wr_q       <= 2'b00;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cs_q       <= cs_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign M_RDATA  = rdata_q;
    assign M_ACK    = ack_q;
    assign M_ERR    = err_q;
    assign S_CS     = cs_q;
    assign S_ADDR   = addr_q[15:0];
    assign S_WR_EN  = wr_q;
    assign S_WDATA  = wdata_q;
    assign ERR_ADDR = err_addr_q;
    assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Bench for mem_bus_decoder: table of accesses driven through a cycle-level
// slave model, ACK responses scored against a queue, plus hand sequences for
// reset abort, back-to-back, saturation, duplicate tags and a short timeout.
module tb_mem_bus_decoder;
    localparam int NR = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          M_REQ = 1'b0;
    logic [31:0]   M_ADDR = '0;
    logic [1:0]    M_WR_EN = '0;
    logic [31:0]   M_WDATA = '0;
    logic [31:0]   M_RDATA;
    logic          M_ACK, M_ERR;
    logic [NR-1:0] S_CS;
    logic [15:0]   S_ADDR;
    logic [1:0]    S_WR_EN;
    logic [31:0]   S_WDATA;
    logic [32*NR-1:0] S_RDATA = '0;
    logic [NR-1:0] S_READY = '0;
    logic [31:0]   ERR_ADDR;
    logic [7:0]    ERR_CNT;

    // second instance: three regions, two sharing a tag, short timeout
    logic          R2 = 1'b0;
    logic [31:0]   A2 = '0;
    logic [31:0]   RD2;
    logic          ACK2, ERR2;
    logic [2:0]    CS2;
    logic [15:0]   SA2;
    logic [1:0]    SW2;
    logic [31:0]   SWD2, EA2;
    logic [7:0]    EC2;
    logic [95:0]   SRD2 = '0;
    logic [2:0]    SRDY2 = '0;

    always #5 CLK = ~CLK;

    mem_bus_decoder dut (
        .CLK(CLK), .RST(RST), .M_REQ(M_REQ), .M_ADDR(M_ADDR), .M_WR_EN(M_WR_EN),
        .M_WDATA(M_WDATA), .M_RDATA(M_RDATA), .M_ACK(M_ACK), .M_ERR(M_ERR),
        .S_CS(S_CS), .S_ADDR(S_ADDR), .S_WR_EN(S_WR_EN), .S_WDATA(S_WDATA),
        .S_RDATA(S_RDATA), .S_READY(S_READY), .ERR_ADDR(ERR_ADDR), .ERR_CNT(ERR_CNT));

    mem_bus_decoder #(.NUM_REGIONS(3), .REGION_BASE(48'h0040_2000_2000), .TIMEOUT(4)) dut2 (
        .CLK(CLK), .RST(RST), .M_REQ(R2), .M_ADDR(A2), .M_WR_EN(2'b00),
        .M_WDATA(32'h0), .M_RDATA(RD2), .M_ACK(ACK2), .M_ERR(ERR2),
        .S_CS(CS2), .S_ADDR(SA2), .S_WR_EN(SW2), .S_WDATA(SWD2),
        .S_RDATA(SRD2), .S_READY(SRDY2), .ERR_ADDR(EA2), .ERR_CNT(EC2));

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  wr;
        logic [31:0] wdata;
        int          delay;      // CS cycles before READY; -1 = never
        logic [31:0] sdata;
        bit          noise;      // hold READY high on non-selected regions
        logic [NR-1:0] exp_cs;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct { logic [31:0] rdata; bit err; } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[9];
    vec_t uv;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   errcnt_m = 0;

    task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response scoreboard for the main instance.
    always @(negedge CLK) begin
        if (RST) begin
            if (M_ERR && !M_ACK) chk("err_without_ack", M_ERR, 1'b0);
            if (M_ACK) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", M_ACK, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("m_rdata", M_RDATA, mon_e.rdata);
                    chk("m_err", M_ERR, mon_e.err);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int cyc, cs_n, ack_cyc, exp_ack, exp_csn;
        cyc = 0; cs_n = 0; ack_cyc = -1;
        @(posedge CLK); #1;
        M_REQ = 1'b1; M_ADDR = v.addr; M_WR_EN = v.wr; M_WDATA = v.wdata;
        for (int i = 0; i < NR; i++) S_RDATA[32*i +: 32] = v.exp_cs[i] ? v.sdata : ~v.sdata;
        S_READY = v.noise ? ~v.exp_cs : '0;
        sb.push_back('{v.exp_rdata, v.exp_err});
        while (ack_cyc < 0 && cyc < 60) begin
            @(posedge CLK); #1; cyc++;
            M_ADDR = $urandom; M_WDATA = $urandom; M_WR_EN = 2'($urandom);
            if (S_CS != '0) begin
                chk("s_cs", S_CS, v.exp_cs);
                chk("s_addr", S_ADDR, v.addr[15:0]);
                chk("s_wr_en", S_WR_EN, v.wr);
                chk("s_wdata", S_WDATA, v.wdata);
            end else begin
                chk("s_wr_en_idle", S_WR_EN, 2'b00);
            end
            S_READY = ((S_CS != '0 && cs_n == v.delay) ? v.exp_cs : '0) | (v.noise ? ~v.exp_cs : '0);
            if (S_CS != '0) cs_n++;
            if (M_ACK) begin
                ack_cyc = cyc;
                M_REQ = 1'b0; S_READY = '0;
            end
        end
        if (ack_cyc < 0) chk("ack_timeout", 32'd0, 32'd1);
        exp_ack = (v.exp_cs == '0) ? 1 : ((v.delay < 0) ? 17 : v.delay + 2);
        exp_csn = (v.exp_cs == '0) ? 0 : ((v.delay < 0) ? 16 : v.delay + 1);
        chk("ack_latency", ack_cyc, exp_ack);
        chk("cs_cycles", cs_n, exp_csn);
        if (v.exp_err) begin
            if (errcnt_m < 255) errcnt_m++;
            chk("err_addr", ERR_ADDR, v.addr);
        end
        chk("err_cnt", ERR_CNT, errcnt_m);
    endtask

    task automatic d2_access(input logic [31:0] addr, input bit rdy, input logic [2:0] ecs,
                             input int ecsn, input bit eerr, input logic [31:0] erd);
        int cs_n, ack;
        cs_n = 0; ack = -1;
        @(posedge CLK); #1;
        R2 = 1'b1; A2 = addr; SRD2 = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001}; SRDY2 = '0;
        for (int c = 1; c <= 20 && ack < 0; c++) begin
            @(posedge CLK); #1;
            if (ACK2) begin
                ack = c;
                chk("d2_rdata", RD2, erd);
                chk("d2_err", ERR2, eerr);
                R2 = 1'b0; SRDY2 = '0;
            end else if (CS2 != '0) begin
                chk("d2_cs", CS2, ecs);
                cs_n++;
                SRDY2 = rdy ? CS2 : ~ecs;
            end
        end
        if (ack < 0) chk("d2_ack_timeout", 32'd0, 32'd1);
        chk("d2_cs_cycles", cs_n, ecsn);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, second;
        tbl[0] = '{32'h1001_0008, 2'b00, 32'h0,         0, 32'h1234_5678, 1'b0, 2'b10, 1'b0, 32'h1234_5678};
        tbl[1] = '{32'h0040_0004, 2'b11, 32'hCAFE_F00D, 3, 32'h5555_5555, 1'b0, 2'b01, 1'b0, 32'h1234_5678};
        tbl[2] = '{32'h2000_0000, 2'b00, 32'h0,         0, 32'h0,         1'b0, 2'b00, 1'b1, 32'hDEAD_BEEF};
        tbl[3] = '{32'h0040_0010, 2'b00, 32'h0,         1, 32'hA5A5_5A5A, 1'b1, 2'b01, 1'b0, 32'hA5A5_5A5A};
        tbl[4] = '{32'h1001_FFFC, 2'b00, 32'h0,        -1, 32'h0,         1'b1, 2'b10, 1'b1, 32'hDEAD_BEEF};
        tbl[5] = '{32'h1001_0001, 2'b01, 32'h0000_00AB, 0, 32'h7777_7777, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF};
        tbl[6] = '{32'h0041_0000, 2'b00, 32'h0,         0, 32'h0,         1'b0, 2'b00, 1'b1, 32'hDEAD_BEEF};
        tbl[7] = '{32'h0040_0002, 2'b10, 32'h0000_BEEF, 2, 32'h0,         1'b0, 2'b01, 1'b0, 32'hDEAD_BEEF};
        tbl[8] = '{32'h1001_0040, 2'b00, 32'h0,         4, 32'h600D_CAFE, 1'b1, 2'b10, 1'b0, 32'h600D_CAFE};

        // reset state
        #3;
        chk("rst_m_ack", M_ACK, 1'b0);
        chk("rst_m_err", M_ERR, 1'b0);
        chk("rst_m_rdata", M_RDATA, 32'h0);
        chk("rst_s_cs", S_CS, 2'b00);
        chk("rst_s_wr_en", S_WR_EN, 2'b00);
        chk("rst_err_addr", ERR_ADDR, 32'h0);
        chk("rst_err_cnt", ERR_CNT, 8'h0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b1;

        foreach (tbl[k]) run_vec(tbl[k]);

        // back-to-back: request held through ACK with a new address
        sb.push_back('{32'h1111_2222, 1'b0});
        sb.push_back('{32'h3333_4444, 1'b0});
        first = -1; second = -1;
        @(posedge CLK); #1;
        M_REQ = 1'b1; M_ADDR = 32'h1001_0004; M_WR_EN = 2'b00;
        S_RDATA = {32'h1111_2222, 32'h3333_4444}; S_READY = '0;
        for (int c = 1; c <= 12 && second < 0; c++) begin
            @(posedge CLK); #1;
            S_READY = S_CS;
            if (M_ACK) begin
                if (first < 0) begin
                    first = c; M_ADDR = 32'h0040_0008;
                end else begin
                    second = c; M_REQ = 1'b0; S_READY = '0;
                end
            end
        end
        chk("b2b_first_ack", first, 2);
        chk("b2b_second_ack", second, 5);

        // reset in the middle of an access
        @(posedge CLK); #1;
        M_REQ = 1'b1; M_ADDR = 32'h1001_0020; M_WR_EN = 2'b11; M_WDATA = 32'h1357_9BDF; S_READY = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("pre_reset_cs", S_CS, 2'b10);
        #2 RST = 1'b0;
        #1;
        chk("arst_s_cs", S_CS, 2'b00);
        chk("arst_s_wr_en", S_WR_EN, 2'b00);
        chk("arst_s_addr", S_ADDR, 16'h0);
        chk("arst_s_wdata", S_WDATA, 32'h0);
        chk("arst_m_rdata", M_RDATA, 32'h0);
        chk("arst_err_addr", ERR_ADDR, 32'h0);
        chk("arst_err_cnt", ERR_CNT, 8'h0);
        chk("arst_m_ack", M_ACK, 1'b0);
        M_REQ = 1'b0; errcnt_m = 0;
        @(posedge CLK); #1;
        RST = 1'b1;
        uv = '{32'h0040_0000, 2'b00, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 2'b01, 1'b0, 32'h0BAD_F00D};
        run_vec(uv);

        // error counter saturation
        uv = '{32'hF000_0000, 2'b00, 32'h0, 0, 32'h0, 1'b0, 2'b00, 1'b1, 32'hDEAD_BEEF};
        for (int k = 0; k < 300; k++) begin
            uv.addr = 32'hF000_0000 + 32'(k);
            run_vec(uv);
        end
        chk("err_cnt_sat", ERR_CNT, 8'hFF);

        // duplicate tags select the lower region; short timeout on region 2
        d2_access(32'h2000_1234, 1'b1, 3'b001, 1, 1'b0, 32'h0000_0001);
        d2_access(32'h0040_0000, 1'b0, 3'b100, 4, 1'b1, 32'hDEAD_BEEF);
        chk("d2_err_cnt", EC2, 8'd1);
        chk("d2_err_addr", EA2, 32'h0040_0000);

        @(posedge CLK); #1;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
